// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver: configurable data width, oversample factor and
// stop-bit count, 3-sample majority voting, framing/break/parity error flags and
// a one-entry valid/ready holding register with sticky overrun detection.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined     -> a parity bit follows the data bits; parity_err is live and
//                  PARITY_ODD selects odd (1) or even (0) parity.
//   not defined -> no parity bit in the frame; parity_err is tied low.
//
// Parameters:
//   DATA_BITS  : data bits per frame (5..9)
//   OVERSAMPLE : rx_clk cycles per bit (even, >= 8)
//   STOP_BITS  : stop bits checked (1 or 2)
//   PARITY_ODD : 1 = odd parity, 0 = even (parity build only)
//
// Ports:
//   rx_clk     in   clock, OVERSAMPLE x baud
//   enable     in   synchronous active-high reset
//   RX         in   asynchronous serial line, idles high
//   data_out   out  received word (LSB first on the line)
//   valid      out  holding register contains a word
//   ready      in   consumer takes the word when valid && ready
//   frame_err  out  a stop bit of the held word was sampled low
//   parity_err out  parity mismatch in the held word
//   break_det  out  held word was a break (data, parity and stop all low)
//   overrun    out  sticky: a completed frame was dropped (cleared by enable)
// -----------------------------------------------------------------------------
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 rx_clk,
  input  logic                 enable,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_CNT  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
  localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  // Reject illegal configurations at elaboration time.
  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1))
  begin : g_bad_params
    $error("uart_rx_param: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  // Expected parity bit for a data word.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PAR_ODD;
  endfunction
`endif

  logic                 rx_sync_r;
  logic                 rx_prev_r;
  logic [1:0]           hist_r;      // rx_sync two and one cycles ago
  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic [BW-1:0]        bit_r;
  logic                 stop_idx_r;
  logic                 stop_any0_r; // an earlier stop bit of this frame was 0
  logic                 stop_all0_r; // every earlier stop bit of this frame was 0
  logic [DATA_BITS-1:0] shift_r;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_r;
  logic                 par_err_r;
`endif

  logic maj_s;
  logic deliver_s;
  logic fe_s;
  logic bk_s;
  logic pe_s;

  // Input synchronizer and sample history feeding the majority vote.
  always_ff @(posedge rx_clk) begin
    if (enable) begin
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
      hist_r    <= 2'b11;
    end else begin
      rx_sync_r <= RX;
      rx_prev_r <= rx_sync_r;
      hist_r    <= {hist_r[0], rx_sync_r};
    end
  end

  // Vote, delivery strobe and the status of the frame being completed.
  always_comb begin
    maj_s     = maj3(hist_r[1], hist_r[0], rx_sync_r);
    deliver_s = 1'b0;
    if (state_r == S_STOP && cnt_r == LAST_CNT && stop_idx_r == STOP_LAST) begin
      deliver_s = 1'b1;
    end else begin
      deliver_s = 1'b0;
    end
    // The final stop bit is still being voted, so fold it in directly.
    fe_s = stop_any0_r | ~maj_s;
`ifdef UART_RX_PARITY_EN
    pe_s = par_err_r;
    bk_s = (shift_r == {DATA_BITS{1'b0}}) & stop_all0_r & ~maj_s & ~par_bit_r;
`else
    pe_s = 1'b0;
    bk_s = (shift_r == {DATA_BITS{1'b0}}) & stop_all0_r & ~maj_s;
`endif
  end

  // Receive FSM plus the valid/ready holding register.
  always_ff @(posedge rx_clk) begin
    if (enable) begin
      state_r     <= S_IDLE;
      cnt_r       <= CNT_ZERO;
      bit_r       <= BIT_ZERO;
      stop_idx_r  <= 1'b0;
      stop_any0_r <= 1'b0;
      stop_all0_r <= 1'b1;
      shift_r     <= {DATA_BITS{1'b0}};
`ifdef UART_RX_PARITY_EN
      par_bit_r   <= 1'b0;
      par_err_r   <= 1'b0;
`endif
      data_out    <= {DATA_BITS{1'b0}};
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      break_det   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (rx_prev_r && !rx_sync_r) begin
            state_r <= S_START;
            cnt_r   <= CNT_ZERO;
          end
        end
        S_START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r <= CNT_ZERO;
            bit_r <= BIT_ZERO;
            state_r <= maj_s ? S_IDLE : S_DATA;  // high vote: false start
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt_r == LAST_CNT) begin
            cnt_r          <= CNT_ZERO;
            shift_r[bit_r] <= maj_s;
            if (bit_r == LAST_BIT) begin
              stop_idx_r  <= 1'b0;
              stop_any0_r <= 1'b0;
              stop_all0_r <= 1'b1;
`ifdef UART_RX_PARITY_EN
              state_r     <= S_PARITY;
`else
              state_r     <= S_STOP;
`endif
            end else begin
              bit_r <= bit_r + BIT_ONE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_r == LAST_CNT) begin
            cnt_r     <= CNT_ZERO;
            par_bit_r <= maj_s;
            par_err_r <= maj_s ^ parity_bit(shift_r);
            state_r   <= S_STOP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
`endif
        S_STOP: begin
          if (cnt_r == LAST_CNT) begin
            cnt_r <= CNT_ZERO;
            if (stop_idx_r == STOP_LAST) begin
              // Leave at mid stop bit so the next start edge is not missed.
              state_r <= fe_s ? S_WAIT_IDLE : S_IDLE;
            end else begin
              stop_idx_r  <= stop_idx_r + 1'b1;
              stop_any0_r <= stop_any0_r | ~maj_s;
              stop_all0_r <= stop_all0_r & ~maj_s;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_WAIT_IDLE: begin
          if (rx_sync_r) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase

      // A slot frees up in the same cycle the consumer takes the old word.
      if (deliver_s) begin
        if (!valid || ready) begin
          data_out   <= shift_r;
          frame_err  <= fe_s;
          parity_err <= pe_s;
          break_det  <= bk_s;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed testbench for uart_rx_param (default parameters: 8 data bits,
// 16x oversampling, 1 stop bit). Expected words go into a scoreboard queue as
// frames are sent and are popped when the consumer handshake fires.
module tb_uart_rx_param;

`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk;
  logic       enable;
  logic       rx;
  logic       ready;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       break_det;
  logic       overrun;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       bk;
    int         rise;   // expected cycle of valid rising, -1 = not checked
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   word_cnt = 0;
  int   valid_hi_cnt = 0;
  int   rise_cyc = -1;
  logic prev_valid = 1'b0;

  uart_rx_param dut (
    .rx_clk    (clk),
    .enable    (enable),
    .RX        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .break_det (break_det),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Sends one frame starting at a negedge; RX is left at the stop-bit value.
  task automatic send_word(input logic [7:0] d, input logic stop_v,
                           input logic par_flip, input int spike_idx);
    logic [15:0] fr;
    int n;
    fr = 16'h0000;
    for (int i = 0; i < 8; i++) fr[1+i] = d[i];
    n = 9;
`ifdef UART_RX_PARITY_EN
    fr[n] = (^d) ^ par_flip;
    n++;
`else
    fr[15] = par_flip & 1'b0;
`endif
    fr[n] = stop_v;
    n++;
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 16; j++) begin
        rx = (i == spike_idx && j == 7) ? 1'b0 : fr[i];
        @(negedge clk);
      end
    end
  endtask

  // Consumer-side monitor: samples just after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
      if (valid === 1'b1) valid_hi_cnt++;
      prev_valid = valid;
      if (valid === 1'b1 && ready === 1'b1) begin
        word_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_word", {24'h0, data_out}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("word_data", {24'h0, data_out}, {24'h0, e.d});
          chk("word_frame_err", {31'h0, frame_err}, {31'h0, e.fe});
          chk("word_parity_err", {31'h0, parity_err}, {31'h0, e.pe});
          chk("word_break", {31'h0, break_det}, {31'h0, e.bk});
          if (e.rise >= 0) chk("valid_rise_cycle", rise_cyc, e.rise);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0;
    int vh0;
    logic [7:0] d;
    enable = 1'b1;
    rx     = 1'b1;
    ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", {24'h0, data_out}, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
    chk("rst_parity_err", {31'h0, parity_err}, 32'h0);
    chk("rst_break", {31'h0, break_det}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    enable = 1'b0;
    repeat (4) @(negedge clk);

    // Clean frame, latency and single-cycle valid.
    wc0 = word_cnt;
    vh0 = valid_hi_cnt;
    sb.push_back('{8'h55, 1'b0, 1'b0, 1'b0, cyc + 154 + 16 * P});
    send_word(8'h55, 1'b1, 1'b0, -1);
    repeat (32) @(negedge clk);
    chk("t1_words", word_cnt - wc0, 32'd1);
    chk("t1_valid_cycles", valid_hi_cnt - vh0, 32'd1);

    // Overrun: second frame dropped while the first is held.
    ready = 1'b0;
    sb.push_back('{8'hA3, 1'b0, 1'b0, 1'b0, -1});
    send_word(8'hA3, 1'b1, 1'b0, -1);
    repeat (8) @(negedge clk);
    send_word(8'h0F, 1'b1, 1'b0, -1);
    repeat (32) @(negedge clk);
    chk("ovr_valid_held", {31'h0, valid}, 32'h1);
    chk("ovr_data_held", {24'h0, data_out}, 32'hA3);
    chk("ovr_flag", {31'h0, overrun}, 32'h1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    chk("ovr_valid_cleared", {31'h0, valid}, 32'h0);
    chk("ovr_data_kept", {24'h0, data_out}, 32'hA3);
    repeat (50) @(negedge clk);
    chk("ovr_sticky", {31'h0, overrun}, 32'h1);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    chk("ovr_cleared_by_enable", {31'h0, overrun}, 32'h0);
    ready = 1'b1;
    repeat (4) @(negedge clk);

    // Framing error with the line held low afterwards.
    wc0 = word_cnt;
    sb.push_back('{8'h3C, 1'b1, 1'b0, 1'b0, -1});
    send_word(8'h3C, 1'b0, 1'b0, -1);
    repeat (48) @(negedge clk);
    chk("fe_one_word_low", word_cnt - wc0, 32'd1);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("fe_no_extra_word", word_cnt - wc0, 32'd1);
    sb.push_back('{8'h81, 1'b0, 1'b0, 1'b0, -1});
    send_word(8'h81, 1'b1, 1'b0, -1);
    repeat (32) @(negedge clk);
    chk("fe_recovery_word", word_cnt - wc0, 32'd2);

    // Break: 20 bit times low.
    wc0 = word_cnt;
    sb.push_back('{8'h00, 1'b1, 1'b0, 1'b1, -1});
    rx = 1'b0;
    repeat (320) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("break_one_word", word_cnt - wc0, 32'd1);

    // Short glitch is rejected as a false start.
    wc0 = word_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_no_word", word_cnt - wc0, 32'd0);
    chk("glitch_valid", {31'h0, valid}, 32'h0);

    // One-cycle low spike inside data bit 2 is voted out.
    wc0 = word_cnt;
    sb.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, -1});
    send_word(8'hFF, 1'b1, 1'b0, 3);
    repeat (32) @(negedge clk);
    chk("spike_word", word_cnt - wc0, 32'd1);

`ifdef UART_RX_PARITY_EN
    // Even parity on 0x07 needs parity bit 1.
    sb.push_back('{8'h07, 1'b0, 1'b1, 1'b0, -1});
    send_word(8'h07, 1'b1, 1'b1, -1);
    repeat (32) @(negedge clk);
    sb.push_back('{8'h07, 1'b0, 1'b0, 1'b0, -1});
    send_word(8'h07, 1'b1, 1'b0, -1);
    repeat (32) @(negedge clk);
`endif

    // enable mid-frame: held word and the partial frame both vanish.
    ready = 1'b0;
    wc0 = word_cnt;
    send_word(8'h96, 1'b1, 1'b0, -1);
    repeat (32) @(negedge clk);
    chk("abort_pre_valid", {31'h0, valid}, 32'h1);
    chk("abort_pre_data", {24'h0, data_out}, 32'h96);
    d = 8'h5A;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
    rx = d[4];
    repeat (8) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    rx = 1'b1;
    chk("abort_data", {24'h0, data_out}, 32'h0);
    chk("abort_valid", {31'h0, valid}, 32'h0);
    chk("abort_frame_err", {31'h0, frame_err}, 32'h0);
    chk("abort_parity_err", {31'h0, parity_err}, 32'h0);
    chk("abort_break", {31'h0, break_det}, 32'h0);
    chk("abort_overrun", {31'h0, overrun}, 32'h0);
    ready = 1'b1;
    repeat (200) @(negedge clk);
    chk("abort_no_word", word_cnt - wc0, 32'd0);
    chk("abort_valid_late", {31'h0, valid}, 32'h0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
